// File: rtl/fft8_sched_ctrl_if.sv
// Control bundle between the FFT8 sequencer and its sample RAM, butterfly unit and stream ports.
// The master modport is the sequencer; the slave modport is everything around it.
interface fft8_sched_ctrl_if #(
    parameter int FRAME_CNT_W = 8
);
    logic                   en;
    logic                   in_valid;
    logic                   in_ready;
    logic                   wr_en;
    logic [2:0]             wr_addr;
    logic                   bf_valid;
    logic                   bf_ready;
    logic [2:0]             bf_addr_a;
    logic [2:0]             bf_addr_b;
    logic [1:0]             bf_tw;
    logic [1:0]             bf_stage;
    logic                   bf_done;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             out_addr;
    logic                   out_last;
    logic                   frame_done;
    logic                   busy;
    logic                   err;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  en, in_valid, bf_ready, bf_done, out_ready,
        output in_ready, wr_en, wr_addr, bf_valid, bf_addr_a, bf_addr_b, bf_tw, bf_stage,
               out_valid, out_addr, out_last, frame_done, busy, err, frame_cnt
    );

    modport slave (
        output en, in_valid, bf_ready, bf_done, out_ready,
        input  in_ready, wr_en, wr_addr, bf_valid, bf_addr_a, bf_addr_b, bf_tw, bf_stage,
               out_valid, out_addr, out_last, frame_done, busy, err, frame_cnt
    );
endinterface

// File: rtl/fft8_sched_ctrl.sv
// Control sequencer for an 8-point radix-2 DIT FFT: bit-reversed load, 12 serialised
// butterflies on one shared unit, natural-order unload. No sample data passes through here.
module fft8_sched_ctrl #(
    parameter int BF_TIMEOUT  = 15,
    parameter int FRAME_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    fft8_sched_ctrl_if.master bus
);
    localparam int TO_W = (BF_TIMEOUT < 2) ? 1 : $clog2(BF_TIMEOUT);
    localparam logic [TO_W-1:0]        TO_LAST = TO_W'(BF_TIMEOUT - 1);
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD, BF_REQ, BF_WAIT, UNLOAD} state_t;

    state_t                 state;
    logic [2:0]             load_idx;
    logic [2:0]             out_idx;
    logic [1:0]             stage;
    logic [1:0]             bf_idx;
    logic [TO_W-1:0]        to_cnt;
    logic                   in_ready_q;
    logic                   bf_valid_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic                   err_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            load_idx     <= '0;
            out_idx      <= '0;
            stage        <= '0;
            bf_idx       <= '0;
            to_cnt       <= '0;
            in_ready_q   <= 1'b0;
            bf_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state      <= LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        load_idx <= load_idx + 3'd1;
                        if (load_idx == 3'd7) begin
                            state      <= BF_REQ;
                            in_ready_q <= 1'b0;
                            bf_valid_q <= 1'b1;
                            stage      <= '0;
                            bf_idx     <= '0;
                        end
                    end
                end
                BF_REQ: begin
                    if (bus.bf_ready) begin
                        state      <= BF_WAIT;
                        bf_valid_q <= 1'b0;
                        to_cnt     <= '0;
                    end
                end
                BF_WAIT: begin
                    // Only one butterfly in flight, so stage ordering needs no extra tracking.
                    if (bus.bf_done) begin
                        bf_idx <= bf_idx + 2'd1;
                        if (bf_idx == 2'd3 && stage == 2'd2) begin
                            state       <= UNLOAD;
                            stage       <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state      <= BF_REQ;
                            bf_valid_q <= 1'b1;
                            if (bf_idx == 2'd3)
                                stage <= stage + 2'd1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                        stage  <= '0;
                        bf_idx <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (bus.out_ready) begin
                        out_idx <= out_idx + 3'd1;
                        if (out_idx == 3'd7) begin
                            state        <= IDLE;
                            out_valid_q  <= 1'b0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Butterfly operand addressing, one explicit case per stage of the DIT flow graph.
    logic [2:0] addr_a;
    logic [2:0] addr_b;
    logic [1:0] tw;
    logic       bf_active;

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        tw     = '0;
        case (stage)
            2'd0: begin
                addr_a = {bf_idx, 1'b0};
                addr_b = {bf_idx, 1'b1};
                tw     = 2'd0;
            end
            2'd1: begin
                addr_a = {bf_idx[1], 1'b0, bf_idx[0]};
                addr_b = {bf_idx[1], 1'b1, bf_idx[0]};
                tw     = {bf_idx[0], 1'b0};
            end
            2'd2: begin
                addr_a = {1'b0, bf_idx};
                addr_b = {1'b1, bf_idx};
                tw     = bf_idx;
            end
            default: ;
        endcase
    end

    assign bf_active = (state == BF_REQ) || (state == BF_WAIT);

    assign bus.in_ready   = in_ready_q;
    assign bus.wr_en      = bus.in_valid & in_ready_q;
    assign bus.wr_addr    = in_ready_q ? {load_idx[0], load_idx[1], load_idx[2]} : 3'd0;
    assign bus.bf_valid   = bf_valid_q;
    assign bus.bf_addr_a  = bf_active ? addr_a : 3'd0;
    assign bus.bf_addr_b  = bf_active ? addr_b : 3'd0;
    assign bus.bf_tw      = bf_active ? tw : 2'd0;
    assign bus.bf_stage   = stage;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_addr   = out_valid_q ? out_idx : 3'd0;
    assign bus.out_last   = out_valid_q && (out_idx == 3'd7);
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_fft8_sched_ctrl.sv
// Bench for fft8_sched_ctrl: randomised handshakes against a reference built from the
// bit-reverse load order, the DIT butterfly formulas and frame/timeout bookkeeping.
module tb_fft8_sched_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    fft8_sched_ctrl_if #(.FRAME_CNT_W(8)) bus ();

    fft8_sched_ctrl #(.BF_TIMEOUT(15), .FRAME_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int bitrev(input int n);
        int r = 0;
        for (int b = 0; b < 3; b++)
            if (((n >> b) & 1) != 0) r = r | (1 << (2 - b));
        return r;
    endfunction

    task automatic test_reset();
        bus.en = 1'b0; bus.in_valid = 1'b0; bus.bf_ready = 1'b0;
        bus.bf_done = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.bf_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b in_ready=%b bf_valid=%b out_valid=%b, want all 0",
                     bus.busy, bus.in_ready, bus.bf_valid, bus.out_valid);
        end
        checks++;
        if (bus.err !== 1'b0 || bus.frame_cnt !== 8'd0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: err=%b frame_cnt=%0d frame_done=%b, want 0 0 0",
                     bus.err, bus.frame_cnt, bus.frame_done);
        end
        checks++;
        if (bus.wr_addr !== 3'd0 || bus.bf_addr_a !== 3'd0 || bus.bf_addr_b !== 3'd0 ||
            bus.bf_tw !== 2'd0 || bus.bf_stage !== 2'd0 || bus.out_addr !== 3'd0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_addrs: wr=%0d a=%0d b=%0d tw=%0d st=%0d out=%0d last=%b, want all 0",
                     bus.wr_addr, bus.bf_addr_a, bus.bf_addr_b, bus.bf_tw, bus.bf_stage, bus.out_addr, bus.out_last);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_en0: busy=%b, want 0 with en low", bus.busy);
        end
    endtask

    // One full frame with configurable stall behaviour; out_mode 0=toggle 1=random 2=always ready.
    task automatic run_frame(input int in_gap, input int rdy_gap, input int done_min, input int done_max,
                             input int out_mode, input bit stall3, input bit en_jitter);
        int n, cyc, s, j, span, a, b, tw, stall, d, i;
        bit v, r;
        n = 0; cyc = 0;
        while (n < 8 && cyc < 100) begin
            @(negedge clk);
            bus.en = 1'b1;
            v = ($urandom_range(0, in_gap) == 0);
            bus.in_valid = v;
            #1;
            checks++;
            if (bus.in_ready === 1'b1) begin
                if (bus.wr_en !== v || (v && bus.wr_addr !== 3'(bitrev(n)))) begin
                    errors++;
                    $display("FAIL load_wr n=%0d: wr_en=%b wr_addr=%0d, want wr_en=%b wr_addr=%0d",
                             n, bus.wr_en, bus.wr_addr, v, bitrev(n));
                end
                if (v) n++;
            end else if (bus.wr_en !== 1'b0) begin
                errors++;
                $display("FAIL load_wr_en: wr_en=%b with in_ready low, want 0", bus.wr_en);
            end
            cyc++;
        end
        if (n < 8) begin
            errors++;
            $display("FAIL load_timeout: %0d handshakes, want 8", n);
            bus.in_valid = 1'b0;
            return;
        end
        for (int idx = 0; idx < 12; idx++) begin
            s = idx / 4; j = idx % 4; span = 1 << s;
            a = ((j >> s) << (s + 1)) + (j & (span - 1));
            b = a + span;
            tw = (j & (span - 1)) << (2 - s);
            stall = (stall3 && idx == 2) ? 5 : $urandom_range(0, rdy_gap);
            for (int k = 0; k <= stall; k++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.bf_done  = 1'b0;
                bus.bf_ready = (k == stall);
                if (en_jitter) bus.en = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (bus.bf_valid !== 1'b1 || bus.bf_addr_a !== 3'(a) || bus.bf_addr_b !== 3'(b) ||
                    bus.bf_tw !== 2'(tw) || bus.bf_stage !== 2'(s) || bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bf_req idx=%0d cyc=%0d: v=%b a=%0d b=%0d tw=%0d st=%0d rdy_in=%b, want v=1 a=%0d b=%0d tw=%0d st=%0d rdy_in=0",
                             idx, k, bus.bf_valid, bus.bf_addr_a, bus.bf_addr_b, bus.bf_tw, bus.bf_stage,
                             bus.in_ready, a, b, tw, s);
                end
            end
            d = $urandom_range(done_min, done_max);
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                bus.bf_ready = 1'b0;
                bus.bf_done  = (k == d - 1);
                #1;
                checks++;
                if (bus.bf_valid !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bf_wait idx=%0d cyc=%0d: bf_valid=%b busy=%b out_valid=%b, want 0 1 0",
                             idx, k, bus.bf_valid, bus.busy, bus.out_valid);
                end
            end
        end
        i = 0; cyc = 0;
        while (i < 8 && cyc < 100) begin
            @(negedge clk);
            bus.bf_done = 1'b0;
            bus.en = 1'b1;
            r = (out_mode == 0) ? (cyc % 2 == 0) : (out_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = r;
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== 3'(i) || bus.out_last !== (i == 7) ||
                bus.frame_done !== 1'b0 || bus.bf_valid !== 1'b0) begin
                errors++;
                $display("FAIL unload i=%0d: out_valid=%b out_addr=%0d out_last=%b frame_done=%b, want 1 %0d %b 0",
                         i, bus.out_valid, bus.out_addr, bus.out_last, bus.frame_done, i, (i == 7));
            end
            if (r) i++;
            cyc++;
        end
        if (i < 8) begin
            errors++;
            $display("FAIL unload_timeout: %0d results, want 8", i);
            return;
        end
        exp_cnt = (exp_cnt + 1) % 256;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.frame_done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL frame_end: frame_done=%b out_valid=%b busy=%b frame_cnt=%0d, want 1 0 0 %0d",
                     bus.frame_done, bus.out_valid, bus.busy, bus.frame_cnt, exp_cnt);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.frame_done !== 1'b0 || bus.in_ready !== 1'b1 || bus.frame_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL next_frame: frame_done=%b in_ready=%b frame_cnt=%0d, want 0 1 %0d",
                     bus.frame_done, bus.in_ready, bus.frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_directed_frame();
        run_frame(0, 0, 2, 2, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++)
            run_frame(2, 3, 1, 8, 1, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        int n = 0;
        int cyc = 0;
        while (n < 8 && cyc < 100) begin
            @(negedge clk);
            bus.en = 1'b1; bus.in_valid = 1'b1;
            #1;
            if (bus.in_ready === 1'b1) n++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.bf_ready = 1'b1;
        #1;
        checks++;
        if (bus.bf_valid !== 1'b1 || n != 8) begin
            errors++;
            $display("FAIL to_req: bf_valid=%b loads=%0d, want 1 and 8", bus.bf_valid, n);
        end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.bf_ready = 1'b0; bus.en = 1'b0;
            #1;
            checks++;
            if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL to_wait cyc=%0d: busy=%b err=%b frame_done=%b, want 1 0 0",
                         k, bus.busy, bus.err, bus.frame_done);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.frame_cnt !== 8'(exp_cnt) || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL to_abort: err=%b busy=%b frame_cnt=%0d frame_done=%b, want 1 0 %0d 0",
                     bus.err, bus.busy, bus.frame_cnt, bus.frame_done, exp_cnt);
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL to_sticky_idle: err=%b busy=%b, want 1 0", bus.err, bus.busy);
        end
        run_frame(0, 1, 1, 3, 2, 1'b0, 1'b0);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky_frame: err=%b, want 1", bus.err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        checks++;
        if (bus.err !== 1'b0 || bus.frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL to_rst_clear: err=%b frame_cnt=%0d, want 0 0", bus.err, bus.frame_cnt);
        end
    endtask

    task automatic test_mid_load_reset();
        int n = 0;
        int cyc = 0;
        bus.en = 1'b1;
        while (n < 3 && cyc < 50) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            #1;
            if (bus.in_ready === 1'b1) n++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0 || n != 3) begin
            errors++;
            $display("FAIL mid_load_rst: busy=%b in_ready=%b wr_en=%b loads=%0d, want 0 0 0 3",
                     bus.busy, bus.in_ready, bus.wr_en, n);
        end
        rst = 1'b0;
        exp_cnt = 0;
        run_frame(0, 2, 1, 4, 2, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed_frame();
        test_back_to_back();
        test_timeout();
        test_mid_load_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
